i2c_slave_regs: RTL and testbench

//  I2C target (responder) with a register-pointer interface, i.e. the far end of the transactions our

---
 rtl/i2c_slave_regs_pkg.sv | 38 +++
 rtl/i2c_slave_regs_if.sv | 31 +++
 rtl/i2c_slave_regs_bus_sync.sv | 48 ++++
 rtl/i2c_slave_regs.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_regs_pkg.sv
// I2C target shared definitions: bus constants,
// one-hot FSM state encoding and state bit indices.
package i2c_slave_regs_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int RW_BIT = 0;

  localparam logic [ADDR_W-1:0] MPU6050_ADDR = 7'h68;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int S_IDLE     = 0;
  localparam int S_ADDR     = 1;
  localparam int S_ADDR_ACK = 2;
  localparam int S_PTR      = 3;
  localparam int S_PTR_ACK  = 4;
  localparam int S_WR       = 5;
  localparam int S_WR_ACK   = 6;
  localparam int S_RD       = 7;
  localparam int S_RD_ACK   = 8;
  localparam int S_WAIT     = 9;

  typedef enum logic [9:0] {
    IDLE     = 10'b00_0000_0001,
    ADDR     = 10'b00_0000_0010,
    ADDR_ACK = 10'b00_0000_0100,
    PTR      = 10'b00_0000_1000,
    PTR_ACK  = 10'b00_0001_0000,
    WR       = 10'b00_0010_0000,
    WR_ACK   = 10'b00_0100_0000,
    RD       = 10'b00_1000_0000,
    RD_ACK   = 10'b01_0000_0000,
    WAIT     = 10'b10_0000_0000
  } st_t;

endpackage

// File: rtl/i2c_slave_regs_if.sv
// Register-file access bus between the I2C target and
// the register array: master = I2C target, slave = regs.
interface i2c_slave_regs_if
  import i2c_slave_regs_pkg::*;
#(
  parameter int W = DATA_W
);

  logic [W-1:0] reg_addr;
  logic [W-1:0] reg_wdata;
  logic         reg_we;
  logic         reg_re;
  logic [W-1:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );

endinterface

// File: rtl/i2c_slave_regs_bus_sync.sv
// SCL/SDA synchronizers plus edge detect: SCL rise/fall,
// START/STOP pulses (one CLK each) and synced SDA level.
module i2c_bus_sync #(
  parameter int SYNC_SZ = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic I_SCL,
  input  logic I_SDA,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_SZ-1:0] scl_q;
  logic [SYNC_SZ-1:0] sda_q;
  logic               scl_p;
  logic               sda_p;
  logic               scl_s;

  // Idle bus is high, so reset to 1 to avoid a
  // false START/edge after reset release.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_SZ-2:0], I_SCL};
      sda_q <= {sda_q[SYNC_SZ-2:0], I_SDA};
      scl_p <= scl_s;
      sda_p <= sda_s;
    end
  end

  assign scl_s = scl_q[SYNC_SZ-1];
  assign sda_s = sda_q[SYNC_SZ-1];

  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;

  assign start = scl_s & scl_p & sda_p & ~sda_s;
  assign stop  = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with register pointer: decodes address,
// pointer and data, drives ACK/read data open-drain.
module i2c_slave_regs
  import i2c_slave_regs_pkg::*;
#(
  parameter int ADDR_I2C_SZ = ADDR_W,
  parameter int DATA_I2C_SZ = DATA_W,
  parameter logic [ADDR_I2C_SZ-1:0] SLV_ADDR =
    MPU6050_ADDR,
  parameter int SYNC_SZ = 2
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic I_SCL,
  input  logic I_SDA,
  output logic O_SDA_OE,
  output logic O_BUSY,
  output logic O_ERR,
  i2c_slave_regs_if.master rbus
);

  localparam int DW = DATA_I2C_SZ;
  localparam logic [3:0] LAST = 4'(DW - 1);
  localparam logic [3:0] FULL = 4'(DW);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync #(
    .SYNC_SZ (SYNC_SZ)
  ) u_sync (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .I_SCL    (I_SCL),
    .I_SDA    (I_SDA),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  st_t          st, st_n;
  logic [3:0]   cnt, cnt_n;
  logic [DW-1:0] sh, sh_n;
  logic [DW-1:0] ptr, ptr_n;
  logic [DW-1:0] wd, wd_n;
  logic         we, we_n;
  logic         re, re_n;
  logic         busy, busy_n;
  logic         err, err_n;
  logic         oe, oe_n;
  logic         rw, rw_n;
  logic [DW-1:0] byte_in;
  logic [DW-1:0] rdata;
  logic         mid;

  assign rdata   = rbus.reg_rdata;
  assign byte_in = {sh[DW-2:0], sda_s};

  // A STOP or repeated START is itself preceded by one
  // SCL rise, so a byte is only "broken" once at least
  // one full bit before that rise has been clocked.
  assign mid = (st[S_PTR] | st[S_WR] | st[S_RD])
             & (cnt >= 4'd2);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      st   <= IDLE;
      cnt  <= '0;
      sh   <= '0;
      ptr  <= '0;
      wd   <= '0;
      we   <= 1'b0;
      re   <= 1'b0;
      busy <= 1'b0;
      err  <= 1'b0;
      oe   <= 1'b0;
      rw   <= 1'b0;
    end else begin
      st   <= st_n;
      cnt  <= cnt_n;
      sh   <= sh_n;
      ptr  <= ptr_n;
      wd   <= wd_n;
      we   <= we_n;
      re   <= re_n;
      busy <= busy_n;
      err  <= err_n;
      oe   <= oe_n;
      rw   <= rw_n;
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    sh_n   = sh;
    ptr_n  = ptr;
    wd_n   = wd;
    we_n   = 1'b0;
    re_n   = 1'b0;
    busy_n = busy;
    err_n  = err;
    oe_n   = oe;
    rw_n   = rw;

    // Pointer advances the CLK after a write strobe.
    if (we) ptr_n = ptr + 1'b1;

    if (start || stop) begin
      if (mid) err_n = 1'b1;
      cnt_n = '0;
      oe_n  = 1'b0;
      if (start) begin
        st_n = ADDR;
      end else begin
        st_n   = IDLE;
        busy_n = 1'b0;
      end
    end else begin
      unique case (1'b1)
        st[S_IDLE], st[S_WAIT]: begin
        end
        st[S_ADDR]: begin
          if (scl_rise) begin
            sh_n  = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == LAST) begin
              if (byte_in[DW-1:1] == SLV_ADDR) begin
                st_n   = ADDR_ACK;
                busy_n = 1'b1;
                err_n  = 1'b0;
                rw_n   = byte_in[RW_BIT];
              end else begin
                st_n   = WAIT;
                busy_n = 1'b0;
              end
            end
          end
        end
        st[S_ADDR_ACK]: begin
          // First fall drives ACK, second ends slot.
          if (scl_fall) begin
            if (!oe) begin
              oe_n = 1'b1;
            end else begin
              cnt_n = '0;
              if (rw) begin
                sh_n = rdata;
                re_n = 1'b1;
                oe_n = ~rdata[DW-1];
                st_n = RD;
              end else begin
                oe_n = 1'b0;
                st_n = PTR;
              end
            end
          end
        end
        st[S_PTR]: begin
          if (scl_rise) begin
            sh_n  = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == LAST) begin
              ptr_n = byte_in;
              st_n  = PTR_ACK;
            end
          end
        end
        st[S_PTR_ACK]: begin
          if (scl_fall) begin
            if (!oe) begin
              oe_n = 1'b1;
            end else begin
              oe_n  = 1'b0;
              cnt_n = '0;
              st_n  = WR;
            end
          end
        end
        st[S_WR]: begin
          if (scl_rise) begin
            sh_n  = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == LAST) begin
              wd_n = byte_in;
              st_n = WR_ACK;
            end
          end
        end
        st[S_WR_ACK]: begin
          // Only the 9th rise happens in this state.
          if (scl_rise) we_n = 1'b1;
          if (scl_fall) begin
            if (!oe) begin
              oe_n = 1'b1;
            end else begin
              oe_n  = 1'b0;
              cnt_n = '0;
              st_n  = WR;
            end
          end
        end
        st[S_RD]: begin
          if (scl_rise) cnt_n = cnt + 4'd1;
          if (scl_fall) begin
            if (cnt == FULL) begin
              oe_n = 1'b0;
              st_n = RD_ACK;
            end else begin
              sh_n = {sh[DW-2:0], 1'b0};
              oe_n = ~sh[DW-2];
            end
          end
        end
        st[S_RD_ACK]: begin
          if (scl_rise) begin
            if (sda_s == ACK) ptr_n = ptr + 1'b1;
            else              st_n  = WAIT;
          end
          if (scl_fall) begin
            sh_n  = rdata;
            re_n  = 1'b1;
            oe_n  = ~rdata[DW-1];
            cnt_n = '0;
            st_n  = RD;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  assign O_SDA_OE       = oe;
  assign O_BUSY         = busy;
  assign O_ERR          = err;
  assign rbus.reg_addr  = ptr;
  assign rbus.reg_wdata = wd;
  assign rbus.reg_we    = we;
  assign rbus.reg_re    = re;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bus master model, register
// array, write vector table and read/error sequences.
module tb_i2c_slave_regs;
  import i2c_slave_regs_pkg::*;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_line;
  logic O_SDA_OE, O_BUSY, O_ERR;

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];

  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int re_cnt = 0;

  logic [15:0] obs_we [$];
  logic [15:0] exp_we [$];
  logic [7:0]  exp_rd [$];

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ptr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic [7:0] end_ptr;
  } wvec_t;

  wvec_t tbl [5];

  i2c_slave_regs_if rif ();

  always #5 CLK = ~CLK;

  assign sda_line = sda_m & ~O_SDA_OE;
  assign rif.reg_rdata = mem[rif.reg_addr];

  i2c_slave_regs dut (
    .CLK      (CLK),
    .RST_n    (RST_n),
    .I_SCL    (scl_m),
    .I_SDA    (sda_line),
    .O_SDA_OE (O_SDA_OE),
    .O_BUSY   (O_BUSY),
    .O_ERR    (O_ERR),
    .rbus     (rif)
  );

  function automatic logic [7:0] init_val(int a);
    if (a == 'h75) return 8'h68;
    return 8'(a * 3 + 1);
  endfunction

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= init_val(i);
    end else if (rif.reg_we) begin
      mem[rif.reg_addr] <= rif.reg_wdata;
    end
  end

  always @(negedge CLK) begin
    if (O_SDA_OE) oe_cnt++;
    if (O_BUSY) busy_cnt++;
    if (rif.reg_re) re_cnt++;
    if (rif.reg_we)
      obs_we.push_back({rif.reg_addr, rif.reg_wdata});
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clk_wait(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic xfer_bit(input logic b, output logic r);
    sda_m = b;
    clk_wait(4);
    scl_m = 1'b1;
    clk_wait(4);
    r = sda_line;
    clk_wait(4);
    scl_m = 1'b0;
    clk_wait(4);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    clk_wait(4);
    scl_m = 1'b1;
    clk_wait(8);
    sda_m = 1'b0;
    clk_wait(8);
    scl_m = 1'b0;
    clk_wait(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    clk_wait(4);
    scl_m = 1'b1;
    clk_wait(8);
    sda_m = 1'b1;
    clk_wait(8);
  endtask

  task automatic write_byte(input logic [7:0] b,
                            output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], r);
    xfer_bit(1'b1, r);
    ack = (r == ACK);
  endtask

  task automatic read_byte(input logic ack,
                           output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, r);
      b[i] = r;
    end
    xfer_bit(ack ? ACK : NACK, r);
  endtask

  task automatic check_we(string nm);
    chk({nm, "_we_n"}, obs_we.size(), exp_we.size());
    while (exp_we.size() > 0 && obs_we.size() > 0)
      chk({nm, "_we"}, obs_we.pop_front(),
          exp_we.pop_front());
    exp_we.delete();
    obs_we.delete();
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a;
    i2c_start();
    write_byte({7'h68, 1'b0}, a);
    chk("ptr_addr_ack", a, 1'b1);
    write_byte(p, a);
    chk("ptr_ack", a, 1'b1);
  endtask

  initial begin
    logic       a;
    logic [7:0] b;
    logic [7:0] d;
    int         oe0, bz0, re0;

    tbl[0] = '{7'h68, 8'h6B, 1, 8'h00, 8'h00, 1'b1, 8'h6C};
    tbl[1] = '{7'h68, 8'hFF, 2, 8'h11, 8'h22, 1'b1, 8'h01};
    tbl[2] = '{7'h69, 8'h10, 1, 8'h33, 8'h00, 1'b0, 8'h01};
    tbl[3] = '{7'h68, 8'h20, 2, 8'hA5, 8'h5A, 1'b1, 8'h22};
    tbl[4] = '{7'h00, 8'h30, 1, 8'h44, 8'h00, 1'b0, 8'h22};

    for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);

    clk_wait(5);
    chk("rst_oe", O_SDA_OE, 1'b0);
    chk("rst_busy", O_BUSY, 1'b0);
    chk("rst_err", O_ERR, 1'b0);
    chk("rst_addr", rif.reg_addr, 8'h00);
    chk("rst_wdata", rif.reg_wdata, 8'h00);
    chk("rst_we", rif.reg_we, 1'b0);
    chk("rst_re", rif.reg_re, 1'b0);
    RST_n = 1'b1;
    clk_wait(5);

    for (int i = 0; i < 5; i++) begin
      oe0 = oe_cnt;
      bz0 = busy_cnt;
      i2c_start();
      write_byte({tbl[i].dev, 1'b0}, a);
      chk("w_addr_ack", a, tbl[i].ack);
      if (tbl[i].ack) begin
        write_byte(tbl[i].ptr, a);
        chk("w_ptr_ack", a, 1'b1);
        for (int j = 0; j < tbl[i].n; j++) begin
          d = (j == 0) ? tbl[i].d0 : tbl[i].d1;
          b = tbl[i].ptr + 8'(j);
          exp_we.push_back({b, d});
          exp_mem[b] = d;
          write_byte(d, a);
          chk("w_data_ack", a, 1'b1);
        end
      end
      i2c_stop();
      clk_wait(4);
      chk("w_end_ptr", rif.reg_addr, tbl[i].end_ptr);
      chk("w_busy_stop", O_BUSY, 1'b0);
      if (!tbl[i].ack) begin
        chk("nack_oe_seen", oe_cnt - oe0, 0);
        chk("nack_busy_seen", busy_cnt - bz0, 0);
      end
      check_we("w");
    end

    // Single read of WHO_AM_I via repeated START.
    set_ptr(8'h75);
    re0 = re_cnt;
    i2c_start();
    write_byte({7'h68, 1'b1}, a);
    chk("rd_addr_ack", a, 1'b1);
    chk("rd_busy", O_BUSY, 1'b1);
    exp_rd.push_back(exp_mem[8'h75]);
    read_byte(1'b0, b);
    chk("rd_byte", b, exp_rd.pop_front());
    i2c_stop();
    clk_wait(4);
    chk("rd_re_n", re_cnt - re0, 1);
    chk("rd_ptr", rif.reg_addr, 8'h75);
    chk("rd_busy_stop", O_BUSY, 1'b0);
    check_we("rd");

    // Burst read of six registers.
    set_ptr(8'h3B);
    re0 = re_cnt;
    i2c_start();
    write_byte({7'h68, 1'b1}, a);
    chk("br_addr_ack", a, 1'b1);
    for (int i = 0; i < 6; i++)
      exp_rd.push_back(exp_mem[8'h3B + i]);
    for (int i = 0; i < 6; i++) begin
      read_byte(i < 5, b);
      chk("br_byte", b, exp_rd.pop_front());
    end
    i2c_stop();
    clk_wait(4);
    chk("br_ptr", rif.reg_addr, 8'h40);
    chk("br_re_n", re_cnt - re0, 6);
    check_we("br");

    // STOP inside a data byte.
    set_ptr(8'h10);
    xfer_bit(1'b1, a);
    xfer_bit(1'b0, a);
    xfer_bit(1'b1, a);
    i2c_stop();
    clk_wait(4);
    chk("er_err", O_ERR, 1'b1);
    chk("er_busy", O_BUSY, 1'b0);
    check_we("er");
    i2c_start();
    write_byte({7'h68, 1'b0}, a);
    chk("er_addr_ack", a, 1'b1);
    chk("er_err_clr", O_ERR, 1'b0);
    i2c_stop();
    clk_wait(4);
    chk("er_err_after", O_ERR, 1'b0);

    // Reset while driving read bit 4 (0x68 -> bit 0).
    set_ptr(8'h75);
    i2c_start();
    write_byte({7'h68, 1'b1}, a);
    chk("rs_addr_ack", a, 1'b1);
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, a);
    chk("rs_oe_bit4", O_SDA_OE, 1'b1);
    RST_n = 1'b0;
    #1;
    chk("rs_oe_async", O_SDA_OE, 1'b0);
    chk("rs_busy", O_BUSY, 1'b0);
    chk("rs_addr", rif.reg_addr, 8'h00);
    scl_m = 1'b1;
    sda_m = 1'b1;
    clk_wait(4);
    RST_n = 1'b1;
    clk_wait(8);
    chk("rs_oe_after", O_SDA_OE, 1'b0);
    chk("rs_busy_after", O_BUSY, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
